// File: rtl/sevenseg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scanner.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    DRIVE
  } scan_state_t;

  localparam logic [6:0] BLANK_SEG = 7'b1111111;

  // Bank is at most 8 digits wide; callers truncate to their own width.
  function automatic logic [7:0] anode_onehot_low(input logic [2:0] idx);
    return ~(8'b0000_0001 << idx);
  endfunction

endpackage

// File: rtl/sevenseg_scanner_decoder.sv
// Hex nibble to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
module sevenseg_scanner_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] address,
  output logic [6:0] data
);

  always_comb begin
    data = BLANK_SEG;
    case (address)
      4'h0: data = 7'b1000000;
      4'h1: data = 7'b1111001;
      4'h2: data = 7'b0100100;
      4'h3: data = 7'b0110000;
      4'h4: data = 7'b0011001;
      4'h5: data = 7'b0010010;
      4'h6: data = 7'b0000010;
      4'h7: data = 7'b1111000;
      4'h8: data = 7'b0000000;
      4'h9: data = 7'b0010000;
      4'hA: data = 7'b0001000;
      4'hB: data = 7'b0000011;
      4'hC: data = 7'b1000110;
      4'hD: data = 7'b0100001;
      4'hE: data = 7'b0000110;
      4'hF: data = 7'b0001110;
      default: data = BLANK_SEG;
    endcase
  end

endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed common-anode display scanner with a frame-aligned load
// handshake so a new value never appears half-updated.
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int unsigned NDIGITS  = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned GUARD    = 500
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   load,
  output logic                   ready,
  input  logic                   lz_blank,
  output logic [6:0]             segments,
  output logic [NDIGITS-1:0]     anode,
  output logic                   frame_start
);

  localparam int unsigned CNT_MAX = (PRESCALE > GUARD) ? PRESCALE : GUARD;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IW      = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] G_LAST   = CW'(GUARD - 1);
  localparam logic [CW-1:0] P_LAST   = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

  scan_state_t          state_q;
  logic [IW-1:0]        idx_q;
  logic [CW-1:0]        cnt_q;
  logic [4*NDIGITS-1:0] shadow_q;
  logic [4*NDIGITS-1:0] pending_q;
  logic                 pend_valid_q;
  logic                 ready_q;
  logic                 frame_start_q;
  logic [6:0]           segments_q;
  logic [NDIGITS-1:0]   anode_q;

  logic [3:0]           nib_d [NDIGITS];
  logic [NDIGITS-1:0]   upper_zero_d;
  logic [3:0]           sel_nib_d;
  logic [6:0]           dec_seg_d;
  logic                 blank_d;
  logic                 wrap_d;
  logic                 commit_d;

  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_nib
      assign nib_d[gi] = shadow_q[4*gi +: 4];
    end
  endgenerate

  // upper_zero_d[i]: nibbles i..NDIGITS-1 are all zero
  always_comb begin
    logic all_zero;
    all_zero     = 1'b1;
    upper_zero_d = '0;
    for (int i = int'(NDIGITS) - 1; i >= 0; i--) begin
      all_zero        = all_zero && (nib_d[i] == 4'h0);
      upper_zero_d[i] = all_zero;
    end
  end

  assign sel_nib_d = nib_d[idx_q];
  assign blank_d   = lz_blank && (idx_q != '0) && upper_zero_d[idx_q];
  assign wrap_d    = enable && (state_q == sevenseg_pkg::DRIVE) &&
                     (cnt_q == P_LAST) && (idx_q == IDX_LAST);
  assign commit_d  = pend_valid_q && ((state_q == sevenseg_pkg::IDLE) || wrap_d);

  sevenseg_scanner_decoder u_dec (
    .address (sel_nib_d),
    .data    (dec_seg_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= sevenseg_pkg::IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      pending_q     <= '0;
      pend_valid_q  <= 1'b0;
      ready_q       <= 1'b1;
      frame_start_q <= 1'b0;
      segments_q    <= BLANK_SEG;
      anode_q       <= '1;
    end else begin
      // Outputs follow the state register by one cycle; enable low darkens at once.
      anode_q <= (enable && state_q == sevenseg_pkg::DRIVE) ?
                 NDIGITS'(anode_onehot_low(3'(idx_q))) : '1;
      segments_q <= (!enable || state_q == sevenseg_pkg::IDLE || blank_d) ?
                    BLANK_SEG : dec_seg_d;
      frame_start_q <= enable && (state_q == sevenseg_pkg::GUARD) &&
                       (idx_q == '0) && (cnt_q == '0);

      if (!enable) begin
        state_q <= sevenseg_pkg::IDLE;
        idx_q   <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          sevenseg_pkg::IDLE: begin
            state_q <= sevenseg_pkg::GUARD;
            idx_q   <= '0;
            cnt_q   <= '0;
          end
          sevenseg_pkg::GUARD: begin
            if (cnt_q == G_LAST) begin
              state_q <= sevenseg_pkg::DRIVE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          sevenseg_pkg::DRIVE: begin
            if (cnt_q == P_LAST) begin
              state_q <= sevenseg_pkg::GUARD;
              cnt_q   <= '0;
              idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= sevenseg_pkg::IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
          end
        endcase
      end

      // ready_q is low whenever a pending value waits, so commit and capture never overlap.
      if (commit_d) begin
        shadow_q     <= pending_q;
        pend_valid_q <= 1'b0;
        ready_q      <= 1'b1;
      end else if (load && ready_q) begin
        pending_q    <= value;
        pend_valid_q <= 1'b1;
        ready_q      <= 1'b0;
      end
    end
  end

  assign ready       = ready_q;
  assign segments    = segments_q;
  assign anode       = anode_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Scoreboard bench: stimulus queues expected digit strobes per frame, a monitor pops them.
module tb_sevenseg_scanner;

  localparam int ND = 4;
  localparam int PS = 8;
  localparam int GD = 2;
  localparam int FRAME = ND * (PS + GD);

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001;
  localparam logic [6:0] SX = 7'b1111111;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        ready;
  logic [6:0]  segments;
  logic [3:0]  anode;
  logic        frame_start;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_fs = 0;

  always #5 clock = ~clock;

  sevenseg_scanner #(.NDIGITS(ND), .PRESCALE(PS), .GUARD(GD)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .value       (value),
    .load        (load),
    .ready       (ready),
    .lz_blank    (lz_blank),
    .segments    (segments),
    .anode       (anode),
    .frame_start (frame_start)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, expv, $time);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    exp_q.push_back('{an: 4'b1110, seg: s0});
    exp_q.push_back('{an: 4'b1101, seg: s1});
    exp_q.push_back('{an: 4'b1011, seg: s2});
    exp_q.push_back('{an: 4'b0111, seg: s3});
  endtask

  task automatic wait_frame(input bit chk_period);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (frame_start !== 1'b1 && n < 200);
    check("frame_start", frame_start, 1'b1);
    if (chk_period) check("frame_period", cyc - last_fs, FRAME);
    last_fs = cyc;
  endtask

  task automatic load_value(input logic [15:0] v);
    value = v;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    check("ready_low_after_load", ready, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // Monitor: each strobe start pops one expected digit; its length is checked when it ends.
  initial begin
    logic [3:0] prev_an;
    bit         tracking;
    int         slen;
    exp_t       e;
    prev_an  = 4'hF;
    tracking = 1'b0;
    slen     = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_an  = 4'hF;
        tracking = 1'b0;
      end else begin
        if (anode !== 4'hF) begin
          if (prev_an === 4'hF) begin
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("strobe_anode", anode, e.an);
              check("strobe_segments", segments, e.seg);
              tracking = 1'b1;
              slen = 1;
            end else begin
              tracking = 1'b0;
            end
          end else if (tracking) begin
            slen++;
          end
        end else if (prev_an !== 4'hF && tracking) begin
          check("strobe_length", slen, PS);
          tracking = 1'b0;
        end
        prev_an = anode;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("reset_idle", {anode, segments, ready, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end

    // Load in IDLE commits on the following cycle.
    load_value(16'h1234);
    @(negedge clock);
    check("ready_after_idle_commit", ready, 1'b1);

    enable = 1'b1;
    wait_frame(1'b0);
    push_frame(S4, S3, S2, S1);

    // New value while digit 1 drives; second load while busy must be dropped.
    repeat (14) @(negedge clock);
    check("digit1_driving", anode, 4'b1101);
    load_value(16'hABCD);
    value = 16'hFFFF;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    value = 16'h0000;
    repeat (10) @(negedge clock);
    check("ready_held_low", ready, 1'b0);

    wait_frame(1'b1);
    check("ready_after_boundary", ready, 1'b1);
    push_frame(SD, SC, SB, SA);

    lz_blank = 1'b1;
    load_value(16'h0050);
    wait_frame(1'b1);
    push_frame(S0, S5, SX, SX);

    load_value(16'h0000);
    wait_frame(1'b1);
    push_frame(S0, SX, SX, SX);

    // Drop enable while digit 2 drives.
    wait_frame(1'b1);
    lz_blank = 1'b0;
    repeat (24) @(negedge clock);
    check("digit2_driving", anode, 4'b1011);
    enable = 1'b0;
    @(negedge clock);
    check("dark_after_disable", {anode, segments}, {4'hF, 7'h7F});
    repeat (3) @(negedge clock);
    check("idle_after_disable", {anode, segments, frame_start}, {4'hF, 7'h7F, 1'b0});

    enable = 1'b1;
    wait_frame(1'b0);
    push_frame(S0, S0, S0, S0);
    wait_frame(1'b1);

    // Reset mid-scan with a load pending.
    load_value(16'h9999);
    repeat (4) @(negedge clock);
    check("ready_low_before_reset", ready, 1'b0);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clock);
    check("reset_mid_scan", {anode, segments, ready, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("ready_after_reset", ready, 1'b1);

    enable = 1'b1;
    wait_frame(1'b0);
    push_frame(S0, S0, S0, S0);
    wait_frame(1'b1);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
